ofmaps_drain_scheduler: RTL and testbench

- Sequences accumulated output-feature-map results out of the MAC array after each compute pass, reading only the enabled lanes over the shared lane-select result bus.
- Emits the results as an AXI4-Stream master, one beat per lane, with tlast at the end of each pixel.
- Pulses accumulator clear once a pixel is drained, counts pixels per layer, and produces the status word returned to the host on the control-3 register.

---
 rtl/ofmaps_drain_scheduler.sv | 165 ++++++++++++++++
 tb/tb_ofmaps_drain_scheduler.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ofmaps_drain_scheduler.sv
// Output feature-map drain scheduler.
// Walks the enabled MAC lanes over the shared lane-select result bus after each
// compute pass and streams one AXI4-Stream beat per lane, with tlast on the final
// lane of the pixel. It then pulses accumulator clear, counts pixels per layer,
// and builds the host-visible status word.
module ofmaps_drain_scheduler #(
    parameter int unsigned MAC_NUM              = 256,
    parameter int unsigned LANE_W               = 8,
    parameter int unsigned ACC_WIDTH            = 32,
    parameter int unsigned C_M_AXIS_TDATA_WIDTH = 32,
    parameter int unsigned PIX_W                = 18
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            layer_start,
    input  logic [PIX_W-1:0]                pixel_total,
    input  logic                            drain_start,
    input  logic [LANE_W:0]                 active_lanes,
    output logic [LANE_W-1:0]               lane_sel,
    input  logic [ACC_WIDTH-1:0]            lane_data,
    output logic                            acc_clear,
    output logic [C_M_AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                            m_axis_tvalid,
    input  logic                            m_axis_tready,
    output logic                            m_axis_tlast,
    output logic                            busy,
    output logic                            drain_done,
    output logic                            layer_done,
    input  logic                            status_clear,
    output logic [31:0]                     status
);

    typedef enum logic [2:0] {
        StIdle,
        StRead,
        StLoad,
        StSend,
        StClear
    } state_e;

    localparam logic [LANE_W:0] MacNumW = MAC_NUM[LANE_W:0];

    state_e                          state_q;
    logic [LANE_W-1:0]               idx_q;
    logic [LANE_W:0]                 n_q;
    logic [PIX_W-1:0]                count_q;
    logic [PIX_W-1:0]                total_q;
    logic [C_M_AXIS_TDATA_WIDTH-1:0] tdata_q;
    logic                            tvalid_q;
    logic                            tlast_q;
    logic                            done_sticky_q;
    logic                            err_sticky_q;

    logic [LANE_W:0]  n_clamped;
    logic             is_last_lane;
    logic [PIX_W-1:0] count_inc;
    logic             pixel_hit;
    logic             handshake;
    logic             proto_err;

    // Derived conditions shared by the FSM, the sticky bits and the outputs.
    always_comb begin
        n_clamped    = (active_lanes > MacNumW) ? MacNumW : active_lanes;
        is_last_lane = ({1'b0, idx_q} == (n_q - 1'b1));
        count_inc    = count_q + 1'b1;
        // pixel_total of zero means an unbounded layer: never terminates.
        pixel_hit    = (total_q != '0) && (count_inc == total_q);
        handshake    = tvalid_q && m_axis_tready;
        proto_err    = (state_q != StIdle) && (layer_start || drain_start);
    end

    // Drain sequencer: READ presents the lane, LOAD captures its result, SEND holds the beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            idx_q    <= '0;
            n_q      <= '0;
            count_q  <= '0;
            total_q  <= '0;
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    // layer_start takes effect first so a coincident drain counts from zero.
                    if (layer_start) begin
                        total_q <= pixel_total;
                        count_q <= '0;
                    end
                    if (drain_start) begin
                        n_q     <= n_clamped;
                        idx_q   <= '0;
                        state_q <= (n_clamped == '0) ? StClear : StRead;
                    end
                end
                StRead: begin
                    state_q <= StLoad;
                end
                StLoad: begin
                    tdata_q  <= C_M_AXIS_TDATA_WIDTH'(lane_data);
                    tlast_q  <= is_last_lane;
                    tvalid_q <= 1'b1;
                    state_q  <= StSend;
                end
                StSend: begin
                    if (handshake) begin
                        tvalid_q <= 1'b0;
                        tlast_q  <= 1'b0;
                        if (tlast_q) begin
                            state_q <= StClear;
                        end else begin
                            idx_q   <= idx_q + 1'b1;
                            state_q <= StRead;
                        end
                    end
                end
                StClear: begin
                    count_q <= pixel_hit ? '0 : count_inc;
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Sticky status bits: a set in the same cycle as status_clear wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_sticky_q <= 1'b0;
            err_sticky_q  <= 1'b0;
        end else begin
            if ((state_q == StClear) && pixel_hit) begin
                done_sticky_q <= 1'b1;
            end else if (status_clear) begin
                done_sticky_q <= 1'b0;
            end
            if (proto_err) begin
                err_sticky_q <= 1'b1;
            end else if (status_clear) begin
                err_sticky_q <= 1'b0;
            end
        end
    end

    // Outputs decoded from registered state only.
    always_comb begin
        lane_sel      = idx_q;
        m_axis_tdata  = tdata_q;
        m_axis_tvalid = tvalid_q;
        m_axis_tlast  = tlast_q;
        busy          = (state_q != StIdle);
        acc_clear     = (state_q == StClear);
        drain_done    = (state_q == StClear);
        layer_done    = (state_q == StClear) && pixel_hit;
        status               = '0;
        status[0]            = busy;
        status[1]            = done_sticky_q;
        status[2]            = err_sticky_q;
        status[3 +: PIX_W]   = count_q;
    end

endmodule

// File: tb/tb_ofmaps_drain_scheduler.sv
// Self-checking bench for ofmaps_drain_scheduler: directed sequence with random lane
// data and random backpressure, checked against a per-pixel beat/count model.
module tb_ofmaps_drain_scheduler;

    localparam int MAC_NUM = 256;
    localparam int LANE_W  = 8;
    localparam int ACC_W   = 32;
    localparam int TW      = 32;
    localparam int PIX_W   = 18;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              layer_start = 1'b0;
    logic [PIX_W-1:0]  pixel_total = '0;
    logic              drain_start = 1'b0;
    logic [LANE_W:0]   active_lanes = '0;
    logic [LANE_W-1:0] lane_sel;
    logic [ACC_W-1:0]  lane_data = '0;
    logic              acc_clear;
    logic [TW-1:0]     m_axis_tdata;
    logic              m_axis_tvalid;
    logic              m_axis_tready = 1'b0;
    logic              m_axis_tlast;
    logic              busy;
    logic              drain_done;
    logic              layer_done;
    logic              status_clear = 1'b0;
    logic [31:0]       status;

    ofmaps_drain_scheduler #(
        .MAC_NUM              (MAC_NUM),
        .LANE_W               (LANE_W),
        .ACC_WIDTH            (ACC_W),
        .C_M_AXIS_TDATA_WIDTH (TW),
        .PIX_W                (PIX_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .layer_start   (layer_start),
        .pixel_total   (pixel_total),
        .drain_start   (drain_start),
        .active_lanes  (active_lanes),
        .lane_sel      (lane_sel),
        .lane_data     (lane_data),
        .acc_clear     (acc_clear),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .busy          (busy),
        .drain_done    (drain_done),
        .layer_done    (layer_done),
        .status_clear  (status_clear),
        .status        (status)
    );

    always #5 clk = ~clk;

    // MAC array model: result of the selected lane appears one cycle later.
    logic [31:0] lane_vals [MAC_NUM];
    always @(posedge clk) lane_data <= lane_vals[lane_sel];

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] got_data [$];
    logic        got_last [$];
    logic [7:0]  got_lane [$];
    int clear_cnt = 0;
    int done_cnt  = 0;
    int layer_cnt = 0;

    // Reference model state.
    int m_total   = 0;
    int m_count   = 0;
    bit m_done    = 1'b0;
    bit m_err     = 1'b0;
    int m_layer   = 0;
    int m_clears  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] exp_status();
        return (32'(m_count) << 3) | (32'(m_err) << 2) | (32'(m_done) << 1);
    endfunction

    task automatic randomize_lanes;
        for (int i = 0; i < MAC_NUM; i++) lane_vals[i] = $urandom;
    endtask

    // Stream monitor, sampled mid-cycle.
    logic        prev_v = 1'b0;
    logic        prev_r = 1'b0;
    logic [31:0] prev_d = '0;
    logic        prev_l = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_v = 1'b0;
            prev_r = 1'b0;
        end else begin
            if (prev_v && !prev_r) begin
                check("hold_tvalid", m_axis_tvalid, 1);
                check("hold_tdata", m_axis_tdata, prev_d);
                check("hold_tlast", m_axis_tlast, prev_l);
            end
            if (m_axis_tvalid && m_axis_tready) begin
                got_data.push_back(m_axis_tdata);
                got_last.push_back(m_axis_tlast);
                got_lane.push_back(lane_sel);
            end
            if (acc_clear) begin
                clear_cnt++;
                check("clear_with_done", drain_done, 1);
            end
            if (drain_done) done_cnt++;
            if (layer_done) layer_cnt++;
            prev_v = m_axis_tvalid;
            prev_r = m_axis_tready;
            prev_d = m_axis_tdata;
            prev_l = m_axis_tlast;
        end
    end

    // One pixel drain. mode: 0 always ready, 1 random ready, 2 five-cycle stall.
    // inject: 1 drain_start during SEND, 2 layer_start+status_clear during SEND.
    task automatic run_drain(input int act, input int mode, input int inject,
                             input bit with_layer, input int tot);
        int n;
        int cyc;
        int stall;
        int d0;
        bit injected;
        n = (act > MAC_NUM) ? MAC_NUM : act;
        got_data.delete();
        got_last.delete();
        got_lane.delete();
        d0 = done_cnt;
        if (with_layer) begin
            layer_start = 1'b1;
            pixel_total = tot[PIX_W-1:0];
            m_total = tot;
            m_count = 0;
        end
        active_lanes = act[LANE_W:0];
        drain_start = 1'b1;
        tick;
        drain_start = 1'b0;
        layer_start = 1'b0;
        if (n == 0) begin
            check("zero_lane_clear", acc_clear, 1);
            check("zero_lane_tvalid", m_axis_tvalid, 0);
        end
        cyc = 0;
        stall = 0;
        injected = 1'b0;
        while (done_cnt == d0 && cyc < 5000) begin
            drain_start  = 1'b0;
            layer_start  = 1'b0;
            status_clear = 1'b0;
            case (mode)
                1: m_axis_tready = 1'($urandom_range(0, 1));
                2: begin
                    if (m_axis_tvalid && stall < 5) begin
                        m_axis_tready = 1'b0;
                        stall++;
                    end else begin
                        m_axis_tready = 1'b1;
                    end
                end
                default: m_axis_tready = 1'b1;
            endcase
            if (inject != 0 && !injected && m_axis_tvalid) begin
                injected = 1'b1;
                m_err = 1'b1;
                if (inject == 1) begin
                    drain_start  = 1'b1;
                    active_lanes = 9'd7;
                end else begin
                    layer_start  = 1'b1;
                    pixel_total  = 18'd5;
                    status_clear = 1'b1;
                    m_done = 1'b0;
                end
            end
            tick;
            cyc++;
        end
        drain_start  = 1'b0;
        layer_start  = 1'b0;
        status_clear = 1'b0;
        check("drain_timeout", (cyc < 5000), 1);
        // Pixel bookkeeping from the layer rules.
        m_clears++;
        if (m_total != 0 && m_count + 1 == m_total) begin
            m_count = 0;
            m_done = 1'b1;
            m_layer++;
        end else begin
            m_count = (m_count + 1) % (1 << PIX_W);
        end
        check("beat_count", got_data.size(), n);
        for (int i = 0; i < got_data.size() && i < n; i++) begin
            check("beat_data", got_data[i], lane_vals[i]);
            check("beat_last", got_last[i], (i == n - 1));
            check("beat_lane", got_lane[i], i);
        end
        check("idle_after", busy, 0);
        check("clear_pulses", clear_cnt, m_clears);
        check("done_pulses", done_cnt, m_clears);
        check("layer_pulses", layer_cnt, m_layer);
        check("status_word", status, exp_status());
    endtask

    initial begin
        int cyc;
        int c0;

        // Reset values.
        randomize_lanes();
        tick;
        check("rst_busy", busy, 0);
        check("rst_tvalid", m_axis_tvalid, 0);
        check("rst_status", status, 0);
        check("rst_lane_sel", lane_sel, 0);
        check("rst_tdata", m_axis_tdata, 0);
        rst_n = 1'b1;
        tick;
        check("post_rst_acc_clear", acc_clear, 0);
        check("post_rst_tlast", m_axis_tlast, 0);

        // Two-pixel layer with fixed lane data.
        for (int i = 0; i < MAC_NUM; i++) lane_vals[i] = 32'h100 + i;
        layer_start = 1'b1;
        pixel_total = 18'd2;
        tick;
        layer_start = 1'b0;
        m_total = 2;
        m_count = 0;
        run_drain(4, 0, 0, 1'b0, 0);
        run_drain(4, 0, 0, 1'b0, 0);
        status_clear = 1'b1;
        tick;
        status_clear = 1'b0;
        m_done = 1'b0;
        check("status_clear_done", status, exp_status());

        // Backpressure, zero lanes, clamp to MAC_NUM.
        randomize_lanes();
        run_drain(4, 2, 0, 1'b0, 0);
        run_drain(0, 0, 0, 1'b0, 0);
        randomize_lanes();
        run_drain(300, 1, 0, 1'b0, 0);

        // Protocol errors; coincident layer_start+drain_start; ignored pixel_total.
        randomize_lanes();
        run_drain(4, 0, 1, 1'b1, 3);
        run_drain(5, 1, 2, 1'b0, 0);
        run_drain(2, 0, 0, 1'b0, 0);
        status_clear = 1'b1;
        tick;
        status_clear = 1'b0;
        m_done = 1'b0;
        m_err = 1'b0;
        check("status_clear_all", status, exp_status());

        // Unbounded layer: no layer_done.
        run_drain(3, 1, 0, 1'b1, 0);
        run_drain(1, 0, 0, 1'b0, 0);

        // Reset mid-packet.
        randomize_lanes();
        got_data.delete();
        got_last.delete();
        got_lane.delete();
        m_axis_tready = 1'b1;
        active_lanes = 9'd4;
        drain_start = 1'b1;
        tick;
        drain_start = 1'b0;
        cyc = 0;
        while (!(got_data.size() >= 1 && m_axis_tvalid) && cyc < 100) begin
            tick;
            cyc++;
        end
        check("second_beat_timeout", (cyc < 100), 1);
        c0 = clear_cnt;
        rst_n = 1'b0;
        #1;
        check("mid_rst_tvalid", m_axis_tvalid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_status", status, 0);
        check("mid_rst_acc_clear", acc_clear, 0);
        check("mid_rst_tlast", m_axis_tlast, 0);
        tick;
        tick;
        rst_n = 1'b1;
        m_total = 0;
        m_count = 0;
        m_done = 1'b0;
        m_err = 1'b0;
        tick;
        tick;
        check("no_clear_after_rst", clear_cnt, c0);
        run_drain(4, 0, 0, 1'b0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
